// File: rtl/iq_modulation.sv
// iq_modulation: quarter-rate IQ upconverter with a small input FIFO.
// Optional build macro IQ_MOD_HOLD_EN: on underflow, re-rotate the last popped pair.
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   mod_en         - block enable; low flushes the FIFO and idles the block
//   I_BB, Q_BB     - signed baseband sample, BB_W bits
//   bb_valid       - baseband sample valid
//   bb_ready       - FIFO can accept a sample this cycle
//   DAC_rdy        - strobe requesting the next IF sample
//   I_IF, Q_IF     - registered signed IF sample, BB_W+1 bits
//   mod_rdy        - one-cycle pulse when I_IF/Q_IF update
//   underflow      - one-cycle pulse when a strobe finds the FIFO empty
//   lo_phase       - LO phase used for the current I_IF/Q_IF
module iq_modulation #(
    parameter int BB_W  = 9,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mod_en,
    input  logic [BB_W-1:0] I_BB,
    input  logic [BB_W-1:0] Q_BB,
    input  logic            bb_valid,
    output logic            bb_ready,
    input  logic            DAC_rdy,
    output logic [BB_W:0]   I_IF,
    output logic [BB_W:0]   Q_IF,
    output logic            mod_rdy,
    output logic            underflow,
    output logic [1:0]      lo_phase
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = BB_W + 1;
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [BB_W-1:0] r_mem_i [DEPTH];
    logic [BB_W-1:0] r_mem_q [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [1:0]      r_phase;
`ifdef IQ_MOD_HOLD_EN
    logic [BB_W-1:0] r_last_i;
    logic [BB_W-1:0] r_last_q;
`endif

    logic            w_en;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_zero;
    logic [BB_W-1:0] w_src_i;
    logic [BB_W-1:0] w_src_q;
    logic [OW-1:0]   w_ext_i;
    logic [OW-1:0]   w_ext_q;
    logic [OW-1:0]   w_rot_i;
    logic [OW-1:0]   w_rot_q;

    assign w_en     = mod_en & ~reset;
    assign w_empty  = (r_count == '0);
    assign bb_ready = w_en & (r_count < L_FULL);
    assign w_push   = bb_valid & bb_ready;
    assign w_pop    = DAC_rdy & ~w_empty;

    // Rotation source: FIFO head, or the retained pair when the FIFO is empty.
    always_comb begin
        w_src_i = r_mem_i[r_rptr];
        w_src_q = r_mem_q[r_rptr];
`ifdef IQ_MOD_HOLD_EN
        w_zero = 1'b0;
        if (w_empty) begin
            w_src_i = r_last_i;
            w_src_q = r_last_q;
        end
`else
        w_zero = w_empty;
`endif
    end

    // Widen before negating so that -(-2^(BB_W-1)) stays exact.
    assign w_ext_i = {w_src_i[BB_W-1], w_src_i};
    assign w_ext_q = {w_src_q[BB_W-1], w_src_q};

    always_comb begin
        w_rot_i = w_ext_i;
        w_rot_q = w_ext_q;
        unique case (r_phase)
            2'd0: begin
                w_rot_i = w_ext_i;
                w_rot_q = w_ext_q;
            end
            2'd1: begin
                w_rot_i = -w_ext_q;
                w_rot_q = w_ext_i;
            end
            2'd2: begin
                w_rot_i = -w_ext_i;
                w_rot_q = -w_ext_q;
            end
            2'd3: begin
                w_rot_i = w_ext_q;
                w_rot_q = -w_ext_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !mod_en) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_phase   <= 2'd0;
            I_IF      <= '0;
            Q_IF      <= '0;
            lo_phase  <= 2'd0;
            mod_rdy   <= 1'b0;
            underflow <= 1'b0;
`ifdef IQ_MOD_HOLD_EN
            r_last_i  <= '0;
            r_last_q  <= '0;
`endif
        end else begin
            mod_rdy   <= 1'b0;
            underflow <= 1'b0;

            if (w_push) begin
                r_mem_i[r_wptr] <= I_BB;
                r_mem_q[r_wptr] <= Q_BB;
                r_wptr          <= r_wptr + AW'(1);
            end

            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
`ifdef IQ_MOD_HOLD_EN
                r_last_i <= r_mem_i[r_rptr];
                r_last_q <= r_mem_q[r_rptr];
`endif
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end

            // Phase advances on every strobe, underflow included.
            if (DAC_rdy) begin
                mod_rdy   <= 1'b1;
                underflow <= w_empty;
                lo_phase  <= r_phase;
                r_phase   <= r_phase + 2'd1;
                I_IF      <= w_zero ? '0 : w_rot_i;
                Q_IF      <= w_zero ? '0 : w_rot_q;
            end
        end
    end

endmodule

// File: tb/tb_iq_modulation.sv
// tb_iq_modulation: directed self-checking bench for iq_modulation.
// Expected IF values are hand-rotated baseband pairs.
module tb_iq_modulation;

    localparam int BB_W = 9;
`ifdef IQ_MOD_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            mod_en = 1'b0;
    logic [BB_W-1:0] I_BB = '0;
    logic [BB_W-1:0] Q_BB = '0;
    logic            bb_valid = 1'b0;
    logic            bb_ready;
    logic            DAC_rdy = 1'b0;
    logic [BB_W:0]   I_IF;
    logic [BB_W:0]   Q_IF;
    logic            mod_rdy;
    logic            underflow;
    logic [1:0]      lo_phase;

    int n_checks = 0;
    int n_errors = 0;

    iq_modulation #(.BB_W(BB_W), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mod_en    (mod_en),
        .I_BB      (I_BB),
        .Q_BB      (Q_BB),
        .bb_valid  (bb_valid),
        .bb_ready  (bb_ready),
        .DAC_rdy   (DAC_rdy),
        .I_IF      (I_IF),
        .Q_IF      (Q_IF),
        .mod_rdy   (mod_rdy),
        .underflow (underflow),
        .lo_phase  (lo_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int q);
        bb_valid = 1'b1;
        I_BB = BB_W'(i);
        Q_BB = BB_W'(q);
        tick();
        bb_valid = 1'b0;
    endtask

    task automatic strobe();
        DAC_rdy = 1'b1;
        tick();
        DAC_rdy = 1'b0;
    endtask

    task automatic check_out(input string tag, input int ei, input int eq,
                             input int eph, input int eund);
        check({tag, ".I"}, $signed(I_IF), ei);
        check({tag, ".Q"}, $signed(Q_IF), eq);
        check({tag, ".ph"}, int'(lo_phase), eph);
        check({tag, ".rdy"}, int'(mod_rdy), 1);
        check({tag, ".und"}, int'(underflow), eund);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst.I", $signed(I_IF), 0);
        check("rst.Q", $signed(Q_IF), 0);
        check("rst.ph", int'(lo_phase), 0);
        check("rst.rdy", int'(mod_rdy), 0);
        check("rst.und", int'(underflow), 0);
        check("rst.bbr", int'(bb_ready), 0);
        reset = 1'b0;
        mod_en = 1'b1;
        #1;
        check("en.bbr", int'(bb_ready), 1);

        // rotation through all four phases
        for (int k = 0; k < 4; k++) push(100, -50);
        check("rot.full", int'(bb_ready), 0);
        strobe();
        check_out("rot0", 100, -50, 0, 0);
        strobe();
        check_out("rot1", 50, 100, 1, 0);
        strobe();
        check_out("rot2", -100, 50, 2, 0);
        strobe();
        check_out("rot3", -50, -100, 3, 0);
        tick();
        check("idle.rdy", int'(mod_rdy), 0);
        check("idle.und", int'(underflow), 0);
        check("idle.I", $signed(I_IF), -50);

        // fill, reject a fifth sample, then drain
        push(1, 2);
        push(3, 4);
        push(5, 6);
        push(7, 8);
        check("full.bbr", int'(bb_ready), 0);
        push(9, 9);
        strobe();
        check_out("full0", 1, 2, 0, 0);
        check("full.free", int'(bb_ready), 1);
        strobe();
        check_out("full1", -4, 3, 1, 0);
        strobe();
        check_out("full2", -5, -6, 2, 0);
        strobe();
        check_out("full3", 8, -7, 3, 0);
        strobe();
        check_out("full.und", HOLD ? 7 : 0, HOLD ? 8 : 0, 0, 1);

        // extreme negative at P2
        push(11, -3);
        strobe();
        check_out("ext1", 3, 11, 1, 0);
        push(-256, -256);
        strobe();
        check_out("ext2", 256, 256, 2, 0);
        strobe();
        check_out("ext.und", HOLD ? -256 : 0, HOLD ? 256 : 0, 3, 1);

        // underflow after popping (30,7) at P0
        push(30, 7);
        strobe();
        check_out("uf0", 30, 7, 0, 0);
        strobe();
        check_out("uf1", HOLD ? -7 : 0, HOLD ? 30 : 0, 1, 1);

        // push and strobe together on an empty FIFO
        bb_valid = 1'b1;
        I_BB = BB_W'(20);
        Q_BB = BB_W'(-9);
        DAC_rdy = 1'b1;
        tick();
        bb_valid = 1'b0;
        DAC_rdy = 1'b0;
        check_out("sim0", HOLD ? -30 : 0, HOLD ? -7 : 0, 2, 1);
        strobe();
        check_out("sim1", -9, -20, 3, 0);

        // push and pop together on a non-empty FIFO
        push(1, 1);
        bb_valid = 1'b1;
        I_BB = BB_W'(2);
        Q_BB = BB_W'(2);
        DAC_rdy = 1'b1;
        tick();
        bb_valid = 1'b0;
        DAC_rdy = 1'b0;
        check_out("pp0", 1, 1, 0, 0);
        strobe();
        check_out("pp1", -2, 2, 1, 0);

        // mid-stream disable
        push(5, 5);
        push(6, 6);
        push(7, 7);
        mod_en = 1'b0;
        tick();
        check("dis.I", $signed(I_IF), 0);
        check("dis.Q", $signed(Q_IF), 0);
        check("dis.ph", int'(lo_phase), 0);
        check("dis.bbr", int'(bb_ready), 0);
        mod_en = 1'b1;
        strobe();
        check_out("reen", 0, 0, 0, 1);
        tick();
        check("reen.rdy", int'(mod_rdy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
